// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Raster timing generator for the pixel-clock domain. Produces the column and
// line counters together with hsync, vsync, display enable and line/frame
// strobes for the game and pixel logic.
//
// Optional build macro: VGA_FRAME_CNT_EN
//   When defined, adds an 8-bit frame counter output (frame_cnt).
//
// Ports:
//   clk         in   pixel clock (or 2x pixel clock used together with ce)
//   reset       in   synchronous, active-high
//   ce          in   pixel advance enable; the raster steps only on ce=1 edges
//   hsync       out  horizontal sync, active level = SYNC_POL
//   vsync       out  vertical sync, active level = SYNC_POL
//   hpos        out  current column, 0..H_TOTAL-1
//   vpos        out  current line, 0..V_TOTAL-1
//   de          out  display enable (visible area)
//   line_start  out  one-clk strobe after the step that sets hpos to 0
//   frame_start out  one-clk strobe after the step that sets (hpos,vpos) to (0,0)
//   frame_cnt   out  [VGA_FRAME_CNT_EN only] frames completed since reset, mod 256
//
// Stepping: ce is a plain enable, not a handshake. On a ce=1 edge the raster
// advances one pixel and every output is reloaded from the new position; on a
// ce=0 edge position/sync/de hold and both strobes drop to 0, so a strobe is
// never wider than one clk even when the generator is stalled.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       de,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Last counter values before wrap.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Region bounds are 11 bits wide so an end bound equal to 1024 (a zero
  // back porch on a 1024-long axis) does not wrap to 0.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEGIN  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEGIN  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  // Next-position logic. Sync and de are decoded from the next position and
  // registered alongside it, so every output in a given cycle belongs to the
  // hpos/vpos shown in that same cycle.
  logic       h_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       de_next;
  logic       hs_active;
  logic       vs_active;

  always_comb begin
    h_wrap = (hpos == H_LAST);
    h_next = h_wrap ? 10'd0 : hpos + 10'd1;
    v_next = vpos;
    if (h_wrap) begin
      v_next = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    end
    de_next   = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
    hs_active = ({1'b0, h_next} >= HS_BEGIN) && ({1'b0, h_next} < HS_END);
    // v_next only moves on a horizontal wrap, so vsync can only change on
    // the step that takes hpos to 0.
    vs_active = ({1'b0, v_next} >= VS_BEGIN) && ({1'b0, v_next} < VS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Parked on the last pixel of the frame, so the first enabled step
      // lands on (0,0) and raises frame_start.
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hpos        <= h_next;
      vpos        <= v_next;
      de          <= de_next;
      hsync       <= hs_active ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_active ? SYNC_POL : ~SYNC_POL;
      line_start  <= h_wrap;
      frame_start <= h_wrap && (vpos == V_LAST);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // first_frame marks that the next (0,0) entry is the one right after
  // reset; that entry opens frame 0 and must not count.
  logic first_frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= 8'd0;
      first_frame <= 1'b1;
    end else if (ce && h_wrap && (vpos == V_LAST)) begin
      if (first_frame) begin
        first_frame <= 1'b0;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Two instances share clk/reset/ce:
//   dut_def  : default 640x480 timing, active-low syncs (800 x 525)
//   dut_tiny : 8/2/2/2 x 4/1/1/1 timing, active-high syncs (14 x 7 = 98 clks)
// Full-frame, ce-stall, mid-frame reset and frame counter scenarios use the
// tiny raster so whole frames fit in a short run.
//
// Tiny raster expectations:
//   de    iff hpos<8  and vpos<4
//   hsync iff hpos in 10..11   (active high)
//   vsync iff vpos == 5        (active high)
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  logic reset;
  logic ce;

  always #5 clk = ~clk;

  logic       d_hsync, d_vsync, d_de, d_line_start, d_frame_start;
  logic [9:0] d_hpos, d_vpos;
  logic       t_hsync, t_vsync, t_de, t_line_start, t_frame_start;
  logic [9:0] t_hpos, t_vpos;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] d_frame_cnt;
  logic [7:0] t_frame_cnt;
`endif

  vga_sync_gen dut_def (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .hpos        (d_hpos),
    .vpos        (d_vpos),
    .de          (d_de),
    .line_start  (d_line_start),
    .frame_start (d_frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (d_frame_cnt)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (2),
    .H_BACK    (2),
    .V_VISIBLE (4),
    .V_FRONT   (1),
    .V_SYNC    (1),
    .V_BACK    (1),
    .SYNC_POL  (1'b1)
  ) dut_tiny (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .hsync       (t_hsync),
    .vsync       (t_vsync),
    .hpos        (t_hpos),
    .vpos        (t_vpos),
    .de          (t_de),
    .line_start  (t_line_start),
    .frame_start (t_frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (t_frame_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference position of the tiny raster, advanced by the driver.
  logic [9:0] eh, ev;
  logic       els, efs;

  // Expected clk numbers of upcoming frame_start pulses.
  logic [31:0] exp_q[$];

  logic [24:0] t_vec;
  assign t_vec = {t_hpos, t_vpos, t_de, t_hsync, t_vsync, t_line_start, t_frame_start};

  function automatic logic [24:0] tiny_expected();
    logic e_de, e_hs, e_vs;
    e_de = (eh < 10'd8) && (ev < 10'd4);
    e_hs = (eh >= 10'd10) && (eh < 10'd12);
    e_vs = (ev == 10'd5);
    return {eh, ev, e_de, e_hs, e_vs, els, efs};
  endfunction

  // ---------------- driver ----------------
  // Applies one clk with the given reset/ce and advances the tiny reference.
  task automatic drive_step(input logic rst_v, input logic ce_v);
    reset = rst_v;
    ce    = ce_v;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_v) begin
      eh = 10'd13; ev = 10'd6; els = 1'b0; efs = 1'b0;
    end else if (ce_v) begin
      if (eh == 10'd13) begin
        eh = 10'd0;
        ev = (ev == 10'd6) ? 10'd0 : ev + 10'd1;
      end else begin
        eh = eh + 10'd1;
      end
      els = (eh == 10'd0);
      efs = els && (ev == 10'd0);
    end else begin
      els = 1'b0; efs = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_step(1'b1, 1'b1);
      total++;
      if ({d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_line_start, d_frame_start} !==
          {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold_def clk=%0d got hpos=%0d vpos=%0d de=%b hs=%b vs=%b ls=%b fs=%b exp 799 524 0 1 1 0 0",
                 i, d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_line_start, d_frame_start);
      end
      total++;
      if (t_vec !== 25'({10'd13, 10'd6, 5'b00000})) begin
        bad++;
        $display("FAIL reset_hold_tiny clk=%0d got=%h exp=%h", i, t_vec, 25'({10'd13, 10'd6, 5'b00000}));
      end
    end
    drive_step(1'b0, 1'b1);
    total++;
    if ({d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_line_start, d_frame_start} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL first_step_def got hpos=%0d vpos=%0d de=%b hs=%b vs=%b ls=%b fs=%b exp 0 0 1 1 1 1 1",
               d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_line_start, d_frame_start);
    end
  endtask

  // One default line, starting from (0,0) left by test_reset.
  task automatic test_line();
    int de_cnt, hs_cnt, hs_first, hs_last;
    logic [9:0]  hv;
    logic [24:0] got, exp_v;
    de_cnt = d_de ? 1 : 0;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int i = 1; i < 800; i++) begin
      drive_step(1'b0, 1'b1);
      hv    = 10'(i);
      got   = {d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_line_start, d_frame_start};
      exp_v = {hv, 10'd0, (i < 640), !((i >= 656) && (i < 752)), 1'b1, 1'b0, 1'b0};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL line_pix hpos_exp=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (d_de) de_cnt++;
      if (!d_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_hpos);
        hs_last = int'(d_hpos);
      end
    end
    drive_step(1'b0, 1'b1);
    total++;
    if ({d_hpos, d_vpos, d_de, d_line_start, d_frame_start} !== {10'd0, 10'd1, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL line_wrap got hpos=%0d vpos=%0d de=%b ls=%b fs=%b exp 0 1 1 1 0",
               d_hpos, d_vpos, d_de, d_line_start, d_frame_start);
    end
    total++;
    if (de_cnt !== 640) begin
      bad++; $display("FAIL line_de_count got=%0d exp=640", de_cnt);
    end
    total++;
    if ({hs_cnt, hs_first, hs_last} !== {32'sd96, 32'sd656, 32'sd751}) begin
      bad++; $display("FAIL line_hsync_window got cnt=%0d first=%0d last=%0d exp 96 656 751", hs_cnt, hs_first, hs_last);
    end
  endtask

  // Two full tiny frames at ce=1.
  task automatic test_frame();
    int   vs_cnt, fs_seen;
    logic prev_vs;
    logic [31:0] exp_c;
    drive_step(1'b1, 1'b1);
    drive_step(1'b0, 1'b1);
    total++;
    if (t_vec !== tiny_expected() || !t_frame_start) begin
      bad++; $display("FAIL frame_entry got=%h exp=%h", t_vec, tiny_expected());
    end
    exp_q.delete();
    exp_q.push_back(cyc + 98);
    vs_cnt = 0; fs_seen = 0; prev_vs = t_vsync;
    for (int i = 0; i < 196; i++) begin
      drive_step(1'b0, 1'b1);
      total++;
      if (t_vec !== tiny_expected()) begin
        bad++; $display("FAIL frame_vec clk=%0d got=%h exp=%h", cyc, t_vec, tiny_expected());
      end
      if (t_vsync) vs_cnt++;
      if (t_vsync && !prev_vs) begin
        total++;
        if ({t_hpos, t_vpos} !== {10'd0, 10'd5}) begin
          bad++; $display("FAIL vsync_edge got hpos=%0d vpos=%0d exp 0 5", t_hpos, t_vpos);
        end
      end
      prev_vs = t_vsync;
      if (t_frame_start) begin
        fs_seen++;
        exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
        total++;
        if (32'(cyc) !== exp_c) begin
          bad++; $display("FAIL frame_period got_clk=%0d exp_clk=%0d", cyc, exp_c);
        end
        exp_q.push_back(cyc + 98);
      end
    end
    total++;
    if (vs_cnt !== 28) begin
      bad++; $display("FAIL vsync_count got=%0d exp=28", vs_cnt);
    end
    total++;
    if (fs_seen !== 2) begin
      bad++; $display("FAIL frame_start_count got=%0d exp=2", fs_seen);
    end
  endtask

  // ce toggling 1,0,1,0: raster advances every other clk.
  task automatic test_ce_alt();
    int   fs_seen;
    logic prev_ls;
    logic [31:0] exp_c;
    drive_step(1'b1, 1'b1);
    exp_q.delete();
    fs_seen = 0; prev_ls = 1'b0;
    for (int i = 0; i < 393; i++) begin
      drive_step(1'b0, (i % 2) == 0);
      total++;
      if (t_vec !== tiny_expected()) begin
        bad++; $display("FAIL ce_alt_vec clk=%0d got=%h exp=%h", cyc, t_vec, tiny_expected());
      end
      total++;
      if (prev_ls && t_line_start) begin
        bad++; $display("FAIL ce_alt_ls_width got=2 exp=1 at clk=%0d", cyc);
      end
      prev_ls = t_line_start;
      if (t_frame_start) begin
        fs_seen++;
        if (exp_q.size() > 0) begin
          exp_c = exp_q.pop_front();
          total++;
          if (32'(cyc) !== exp_c) begin
            bad++; $display("FAIL ce_alt_period got_clk=%0d exp_clk=%0d", cyc, exp_c);
          end
        end
        exp_q.push_back(cyc + 196);
      end
    end
    total++;
    if (fs_seen !== 3) begin
      bad++; $display("FAIL ce_alt_fs_count got=%0d exp=3", fs_seen);
    end
  endtask

  task automatic test_mid_reset();
    drive_step(1'b1, 1'b1);
    drive_step(1'b0, 1'b1);
    for (int i = 0; i < 33; i++) drive_step(1'b0, 1'b1);
    total++;
    if ({t_hpos, t_vpos, t_de} !== {10'd5, 10'd2, 1'b1}) begin
      bad++; $display("FAIL mid_pos got hpos=%0d vpos=%0d de=%b exp 5 2 1", t_hpos, t_vpos, t_de);
    end
    drive_step(1'b1, 1'b1);
    total++;
    if (t_vec !== 25'({10'd13, 10'd6, 5'b00000})) begin
      bad++; $display("FAIL mid_reset_tiny got=%h exp=%h", t_vec, 25'({10'd13, 10'd6, 5'b00000}));
    end
    total++;
    if ({d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_line_start, d_frame_start} !==
        {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_def got hpos=%0d vpos=%0d de=%b hs=%b vs=%b ls=%b fs=%b exp 799 524 0 1 1 0 0",
               d_hpos, d_vpos, d_de, d_hsync, d_vsync, d_line_start, d_frame_start);
    end
    drive_step(1'b0, 1'b1);
    total++;
    if ({t_hpos, t_vpos, t_frame_start, d_hpos, d_vpos, d_frame_start} !==
        {10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b1}) begin
      bad++;
      $display("FAIL mid_release got tiny=%0d,%0d fs=%b def=%0d,%0d fs=%b exp 0,0 1 0,0 1",
               t_hpos, t_vpos, t_frame_start, d_hpos, d_vpos, d_frame_start);
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    drive_step(1'b1, 1'b1);
    total++;
    if (t_frame_cnt !== 8'd0) begin
      bad++; $display("FAIL fcnt_reset got=%0d exp=0", t_frame_cnt);
    end
    drive_step(1'b0, 1'b1);
    for (int i = 0; i < 97; i++) drive_step(1'b0, 1'b1);
    total++;
    if ({t_hpos, t_vpos, t_frame_cnt} !== {10'd13, 10'd6, 8'd0}) begin
      bad++; $display("FAIL fcnt_first_frame got pos=%0d,%0d cnt=%0d exp 13,6 0", t_hpos, t_vpos, t_frame_cnt);
    end
    for (int i = 0; i < 197; i++) drive_step(1'b0, 1'b1);
    total++;
    if ({t_frame_start, t_frame_cnt} !== {1'b1, 8'd3}) begin
      bad++; $display("FAIL fcnt_three got fs=%b cnt=%0d exp 1 3", t_frame_start, t_frame_cnt);
    end
    for (int i = 0; i < 253 * 98 - 1; i++) drive_step(1'b0, 1'b1);
    total++;
    if (t_frame_cnt !== 8'd255) begin
      bad++; $display("FAIL fcnt_255 got=%0d exp=255", t_frame_cnt);
    end
    drive_step(1'b0, 1'b1);
    total++;
    if ({t_frame_start, t_frame_cnt} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL fcnt_wrap got fs=%b cnt=%0d exp 1 0", t_frame_start, t_frame_cnt);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    eh = 10'd13; ev = 10'd6; els = 1'b0; efs = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_ce_alt();
    test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
